// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: drives the register-file read addresses, forwards from EX/MEM
// and MEM/WB, detects load-use hazards and registers the resolved operands into ID/EX.
module id_operand_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned ADDR  = 5,
  parameter int unsigned CNTW  = 32
) (
  input  logic             p_clk,
  input  logic             p_rst_l,
  input  logic             p_if_valid,
  input  logic [31:0]      p_if_instr,
  input  logic             p_flush,
  output logic             p_stall_out,
  output logic [ADDR-1:0]  p_readaddr1,
  output logic [ADDR-1:0]  p_readaddr2,
  input  logic [WIDTH-1:0] p_dout1,
  input  logic [WIDTH-1:0] p_dout2,
  input  logic             p_mem_we,
  input  logic [ADDR-1:0]  p_mem_dst,
  input  logic [WIDTH-1:0] p_mem_result,
  input  logic             p_wb_we,
  input  logic [ADDR-1:0]  p_wb_dst,
  input  logic [WIDTH-1:0] p_wb_data,
  output logic             p_ex_valid,
  output logic [WIDTH-1:0] p_ex_op1,
  output logic [WIDTH-1:0] p_ex_op2,
  output logic [WIDTH-1:0] p_ex_imm,
  output logic [ADDR-1:0]  p_ex_dst,
  output logic             p_ex_we,
  output logic             p_ex_load,
  output logic [5:0]       p_ex_opcode,
  output logic [5:0]       p_ex_funct,
  output logic [CNTW-1:0]  p_stall_cnt
);

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpDaddi = 6'h18;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLd    = 6'h37;

  logic             ex_valid_q, ex_valid_d;
  logic [WIDTH-1:0] ex_op1_q, ex_op1_d;
  logic [WIDTH-1:0] ex_op2_q, ex_op2_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [ADDR-1:0]  ex_dst_q, ex_dst_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_load_q, ex_load_d;
  logic [5:0]       ex_opcode_q, ex_opcode_d;
  logic [5:0]       ex_funct_q, ex_funct_d;
  logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

  logic [5:0]       opcode;
  logic [ADDR-1:0]  rs, rt, rd;
  logic             dec_we, dec_load, hazard, stall;
  logic [WIDTH-1:0] fwd1, fwd2;

  always_comb begin
    opcode = p_if_instr[31:26];
    rs     = ADDR'(p_if_instr[25:21]);
    rt     = ADDR'(p_if_instr[20:16]);
    rd     = ADDR'(p_if_instr[15:11]);
    dec_we = (opcode == OpRType) || (opcode == OpAddi) || (opcode == OpDaddi) ||
             (opcode == OpLw) || (opcode == OpLd);
    dec_load = (opcode == OpLw) || (opcode == OpLd);
  end

  assign p_readaddr1 = rs;
  assign p_readaddr2 = rt;

  // EX/MEM beats MEM/WB; MEM/WB also covers the register file being written this same cycle.
  always_comb begin
    fwd1 = p_dout1;
    if (rs == '0)                         fwd1 = '0;
    else if (p_mem_we && p_mem_dst == rs) fwd1 = p_mem_result;
    else if (p_wb_we && p_wb_dst == rs)   fwd1 = p_wb_data;

    fwd2 = p_dout2;
    if (rt == '0)                         fwd2 = '0;
    else if (p_mem_we && p_mem_dst == rt) fwd2 = p_mem_result;
    else if (p_wb_we && p_wb_dst == rt)   fwd2 = p_wb_data;
  end

  // rt is compared even for formats that do not read it; a spurious stall is harmless.
  always_comb begin
    hazard = ex_valid_q && ex_load_q && (ex_dst_q != '0) && p_if_valid &&
             ((ex_dst_q == rs) || (ex_dst_q == rt));
    stall  = hazard && !p_flush;
  end

  assign p_stall_out = stall;

  always_comb begin
    ex_op1_d    = fwd1;
    ex_op2_d    = fwd2;
    ex_imm_d    = {{(WIDTH-16){p_if_instr[15]}}, p_if_instr[15:0]};
    ex_opcode_d = opcode;
    ex_funct_d  = p_if_instr[5:0];
    ex_dst_d    = dec_we ? ((opcode == OpRType) ? rd : rt) : '0;
    ex_we_d     = dec_we;
    ex_load_d   = dec_load;
    ex_valid_d  = 1'b1;
    if (p_flush || hazard || !p_if_valid) begin
      ex_valid_d = 1'b0;
      ex_we_d    = 1'b0;
      ex_load_d  = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge p_clk) begin
    if (!p_rst_l) begin
      ex_valid_q  <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_imm_q    <= '0;
      ex_dst_q    <= '0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_opcode_q <= '0;
      ex_funct_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_imm_q    <= ex_imm_d;
      ex_dst_q    <= ex_dst_d;
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      ex_opcode_q <= ex_opcode_d;
      ex_funct_q  <= ex_funct_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign p_ex_valid  = ex_valid_q;
  assign p_ex_op1    = ex_op1_q;
  assign p_ex_op2    = ex_op2_q;
  assign p_ex_imm    = ex_imm_q;
  assign p_ex_dst    = ex_dst_q;
  assign p_ex_we     = ex_we_q;
  assign p_ex_load   = ex_load_q;
  assign p_ex_opcode = ex_opcode_q;
  assign p_ex_funct  = ex_funct_q;
  assign p_stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the dual-port register file.
- Takes the IF/ID instruction and drives the two register-file read addresses.
- Takes the two read data values, applies EX/MEM and MEM/WB forwarding, and detects load-use hazards.
- Registers the resolved operands into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- WIDTH, 64, datapath width (matches the `WIDTH` define).
- ADDR, 5, register address width (matches the `ADDR` define).
- CNTW, 32, stall performance-counter width.

Ports:
- p_clk  in  1  clock, all state on rising edge.
- p_rst_l  in  1  synchronous active-low reset.
- p_if_valid  in  1  IF/ID holds a valid instruction.
- p_if_instr  in  32  IF/ID instruction word.
- p_flush  in  1  branch/exception flush from EX.
- p_stall_out  out  1  hold fetch and IF/ID this cycle.
- p_readaddr1  out  ADDR  register-file read port 1 address (rs).
- p_readaddr2  out  ADDR  register-file read port 2 address (rt).
- p_dout1  in  WIDTH  register-file read data 1.
- p_dout2  in  WIDTH  register-file read data 2.
- p_mem_we  in  1  EX/MEM result will be written back.
- p_mem_dst  in  ADDR  EX/MEM destination register.
- p_mem_result  in  WIDTH  EX/MEM ALU result.
- p_wb_we  in  1  MEM/WB write enable (same signal drives p_we of the register file).
- p_wb_dst  in  ADDR  MEM/WB destination register.
- p_wb_data  in  WIDTH  MEM/WB write data.
- p_ex_valid  out  1  ID/EX slot valid.
- p_ex_op1  out  WIDTH  resolved rs operand.
- p_ex_op2  out  WIDTH  resolved rt operand.
- p_ex_imm  out  WIDTH  sign-extended instr[15:0].
- p_ex_dst  out  ADDR  destination register.
- p_ex_we  out  1  instruction writes a register.
- p_ex_load  out  1  instruction is a load.
- p_ex_opcode  out  6  instr[31:26].
- p_ex_funct  out  6  instr[5:0].
- p_stall_cnt  out  CNTW  saturating count of load-use stall cycles.

Behaviour:
- Field decode:
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].
  - p_readaddr1 = rs and p_readaddr2 = rt, combinational, always driven.
- Destination: opcode 0x00 (R-type) selects rd; all other opcodes select rt.
- Write-enable class:
  - p_ex_we=1 for R-type, ADDI 0x08, DADDI 0x18, LW 0x23, LD 0x37.
  - All other opcodes give p_ex_we=0 and p_ex_dst=0.
- Load class: p_ex_load=1 for LW 0x23 and LD 0x37 only.
- Forwarding (combinational, per operand, source register s):
  - s==0 gives 0.
  - Else if p_mem_we && p_mem_dst==s, gives p_mem_result.
  - Else if p_wb_we && p_wb_dst==s, gives p_wb_data (covers same-cycle register-file write).
  - Else gives the register-file data.
  - EX/MEM has priority over MEM/WB.
- Load-use hazard:
  - Condition: p_ex_valid && p_ex_load && p_ex_dst!=0 && p_if_valid && (p_ex_dst==rs || p_ex_dst==rt).
  - rt is compared regardless of format.
  - When the hazard holds: p_stall_out=1 (combinational), the next ID/EX is a bubble (p_ex_valid=0, p_ex_we=0, p_ex_load=0; other fields don't-care), and p_stall_cnt increments.
  - Stall lasts exactly one cycle, because the bubble clears the condition.
- Flush:
  - p_flush=1 loads a bubble on the next edge and forces p_stall_out=0.
  - Flush overrides stall and suppresses the counter increment.
- Normal advance: when p_if_valid=0, the next ID/EX is a bubble.
- Latency: one cycle from IF/ID to ID/EX outputs; operands are sampled the cycle the instruction sits in ID.
- p_stall_cnt saturates at all-ones and never wraps.
- Reset (p_rst_l=0 at a rising edge): all registered outputs go to 0, p_stall_cnt goes to 0.
  - Reset overrides flush/stall.
  - Mid-operation reset discards the in-flight ID/EX instruction.
  - p_stall_out follows its combinational equation; with p_ex_valid=0 after reset it is 0.

Test Plan:
- Forwarding priority: regfile r3=0x10, EX/MEM writes r3=0x20, WB writes r3=0x30; issue DADD r1,r3,r3 (0x0063082C) -> p_ex_op1=p_ex_op2=0x20, p_ex_dst=1, p_ex_we=1.
- r0 guard: p_mem_we=1, p_mem_dst=0, p_mem_result=0xFF; instruction reads rs=0 -> p_ex_op1=0.
- Load-use: LD r5,0(r2), then DADD r6,r5,r4 -> one cycle p_stall_out=1, one bubble (p_ex_valid=0), p_stall_cnt=1; DADD then issues with op1=WB/MEM forwarded load data.
- Flush during stall: same hazard with p_flush=1 that cycle -> p_stall_out=0, bubble, p_stall_cnt stays 0.
- Immediate/dst: ADDI r7,r0,0xFFF0 (0x2007FFF0) -> p_ex_imm=0xFFFFFFFFFFFFFFF0, p_ex_dst=7, p_ex_load=0.
- Reset/saturation: with CNTW=2, four stalls -> p_stall_cnt=3; then p_rst_l=0 one edge -> all outputs 0.
